// File: rtl/operand_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | operand_scoreboard                                                         |
// | Register-hazard scoreboard gating issue into operand preparation.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module operand_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31,
    parameter int STALL_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                issueValid,
    output logic                issueReady,
    input  logic [4:0]          reg1,
    input  logic [4:0]          reg2,
    input  logic                aluSRC,
    input  logic                memWriteFlag,
    input  logic                regWrite,
    input  logic [4:0]          writeRegister,
    input  logic                wbValid,
    input  logic [4:0]          wbRegister,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pendingMask,
    output logic                busy,
    output logic [STALL_W-1:0]  stallCount,
    output logic                wbError
);

    localparam logic [NUM_REGS-1:0] c_ONE       = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [NUM_REGS-1:0] c_ZERO_MASK = c_ONE << ZERO_REG;
    localparam logic [4:0]          c_ZERO_IDX  = 5'(ZERO_REG);

    logic [NUM_REGS-1:0] r_pending;
    logic                r_busy;
    logic [STALL_W-1:0]  r_stall;
    logic                r_wb_error;

    logic [NUM_REGS-1:0] w_visible;
    logic [NUM_REGS-1:0] w_set_vec;
    logic [NUM_REGS-1:0] w_clr_vec;
    logic [NUM_REGS-1:0] w_next_pending;
    logic                w_use_reg2;
    logic                w_hazard;
    logic                w_accept;
    logic                w_stall;
    logic                w_wb_orphan;

    // Hazard sees the pre-edge mask: a same-cycle writeback does not unblock.
    assign w_visible  = r_pending & ~c_ZERO_MASK;
    assign w_use_reg2 = ~aluSRC | memWriteFlag;
    assign w_hazard   = w_visible[reg1]
                      | (w_use_reg2 & w_visible[reg2])
                      | (regWrite & w_visible[writeRegister]);

    assign issueReady = ~w_hazard & ~flush & ~reset;
    assign w_accept   = issueValid & issueReady;
    assign w_stall    = issueValid & ~issueReady;

    assign w_set_vec   = (w_accept & regWrite & (writeRegister != c_ZERO_IDX))
                       ? (c_ONE << writeRegister) : '0;
    assign w_clr_vec   = wbValid ? (c_ONE << wbRegister) : '0;
    assign w_wb_orphan = wbValid & (wbRegister != c_ZERO_IDX) & ~w_visible[wbRegister];

    // Set is applied after clear so it wins on a collision; flush beats both.
    assign w_next_pending = flush ? '0 : ((r_pending & ~w_clr_vec) | w_set_vec);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending  <= '0;
            r_busy     <= 1'b0;
            r_stall    <= '0;
            r_wb_error <= 1'b0;
        end else begin
            r_pending <= w_next_pending;
            r_busy    <= |w_next_pending;
            if (w_stall && (r_stall != '1)) begin
                r_stall <= r_stall + STALL_W'(1);
            end
            if (w_wb_orphan) begin
                r_wb_error <= 1'b1;
            end
        end
    end

    assign pendingMask = r_pending;
    assign busy        = r_busy;
    assign stallCount  = r_stall;
    assign wbError     = r_wb_error;

endmodule
`default_nettype wire

// File: tb/tb_operand_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_operand_scoreboard                                                      |
// | Directed plus randomized bench with a register-array reference model.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_operand_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        issueValid;
    logic        issueReady;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic        aluSRC;
    logic        memWriteFlag;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic        wbValid;
    logic [4:0]  wbRegister;
    logic        flush;
    logic [31:0] pendingMask;
    logic        busy;
    logic [15:0] stallCount;
    logic        wbError;

    operand_scoreboard #(
        .NUM_REGS (32),
        .ZERO_REG (31),
        .STALL_W  (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .issueValid    (issueValid),
        .issueReady    (issueReady),
        .reg1          (reg1),
        .reg2          (reg2),
        .aluSRC        (aluSRC),
        .memWriteFlag  (memWriteFlag),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .wbValid       (wbValid),
        .wbRegister    (wbRegister),
        .flush         (flush),
        .pendingMask   (pendingMask),
        .busy          (busy),
        .stallCount    (stallCount),
        .wbError       (wbError)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one flag per architectural register.
    bit m_pend [32];
    bit m_err;
    int m_stall;
    bit m_accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_is_pending(input logic [4:0] r);
        return (r != 5'd31) && m_pend[r];
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) m[i] = m_pend[i];
        return m;
    endfunction

    function automatic bit m_ready();
        bit raw_a, raw_b, waw;
        raw_a = m_is_pending(reg1);
        raw_b = (!aluSRC || memWriteFlag) && m_is_pending(reg2);
        waw   = regWrite && m_is_pending(writeRegister);
        return !reset && !flush && !(raw_a || raw_b || waw);
    endfunction

    // One clock: check combinational ready, advance model at the edge, check state.
    task automatic tick();
        bit rdy;
        #1;
        rdy = m_ready();
        check("issueReady", {31'd0, issueReady}, {31'd0, rdy});
        @(posedge clock);
        m_accepted = issueValid && rdy;
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_err   = 1'b0;
            m_stall = 0;
        end else begin
            if (issueValid && !rdy && m_stall < 65535) m_stall++;
            if (wbValid && wbRegister != 5'd31 && !m_pend[wbRegister]) m_err = 1'b1;
            if (wbValid) m_pend[wbRegister] = 1'b0;
            if (m_accepted && regWrite && writeRegister != 5'd31) m_pend[writeRegister] = 1'b1;
            if (flush) foreach (m_pend[i]) m_pend[i] = 1'b0;
        end
        #1;
        check("pendingMask", pendingMask, m_mask());
        check("busy", {31'd0, busy}, {31'd0, (m_mask() != 0)});
        check("stallCount", {16'd0, stallCount}, m_stall);
        check("wbError", {31'd0, wbError}, {31'd0, m_err});
        @(negedge clock);
    endtask

    task automatic expect_ready(input string tag, input logic v);
        #1;
        check(tag, {31'd0, issueReady}, {31'd0, v});
    endtask

    task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic alu, input logic mw, input logic rw, input logic [4:0] wr);
        issueValid    = v;
        reg1          = r1;
        reg2          = r2;
        aluSRC        = alu;
        memWriteFlag  = mw;
        regWrite      = rw;
        writeRegister = wr;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        reset = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0);
        wbValid = 1'b0; wbRegister = '0; flush = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_err = 1'b0; m_stall = 0; m_accepted = 1'b0;

        expect_ready("ready_in_reset", 1'b0);
        tick(); tick();
        reset = 1'b0;
        check("rst_mask", pendingMask, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {16'd0, stallCount}, 32'd0);
        check("rst_wberr", {31'd0, wbError}, 32'd0);

        // First producer sets register 3
        issue(1, 1, 2, 0, 0, 1, 3);
        expect_ready("t1_ready", 1'b1);
        tick();
        check("t1_mask", pendingMask, 32'h0000_0008);
        check("t1_busy", {31'd0, busy}, 32'd1);

        // Dependent consumer stalls through the writeback cycle
        issue(1, 3, 0, 1, 0, 0, 0);
        repeat (4) tick();
        wbValid = 1'b1; wbRegister = 5'd3;
        expect_ready("t2_wb_cycle", 1'b0);
        tick();
        wbValid = 1'b0;
        expect_ready("t2_after_wb", 1'b1);
        check("t2_stall", {16'd0, stallCount}, 32'd5);
        check("t2_mask", pendingMask, 32'h0);
        tick();

        // Immediate operand masks reg2 unless it is store data
        issue(1, 0, 0, 1, 0, 1, 3);
        tick();
        issue(1, 4, 3, 1, 0, 0, 0);
        expect_ready("t3_imm", 1'b1);
        tick();
        issue(1, 4, 3, 1, 1, 0, 0);
        expect_ready("t3_store", 1'b0);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0);
        wbValid = 1'b1; wbRegister = 5'd3;
        tick();
        wbValid = 1'b0;

        // Zero register never becomes pending
        issue(1, 31, 31, 0, 0, 1, 31);
        expect_ready("t4_first", 1'b1);
        tick();
        expect_ready("t4_second", 1'b1);
        tick();
        check("t4_bit31", {31'd0, pendingMask[31]}, 32'd0);

        // Flush overrides same-cycle clear and issue
        issue(1, 0, 0, 0, 0, 1, 3); tick();
        issue(1, 0, 0, 0, 0, 1, 5); tick();
        check("t5_mask_35", pendingMask, 32'h0000_0028);
        issue(1, 0, 0, 0, 0, 1, 6);
        flush = 1'b1; wbValid = 1'b1; wbRegister = 5'd5;
        expect_ready("t5_flush_ready", 1'b0);
        tick();
        flush = 1'b0; wbValid = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0);
        check("t5_mask", pendingMask, 32'h0);
        check("t5_wberr", {31'd0, wbError}, 32'd0);

        // Orphan writeback is sticky
        wbValid = 1'b1; wbRegister = 5'd7;
        tick();
        wbValid = 1'b0;
        check("t6_wberr", {31'd0, wbError}, 32'd1);
        repeat (3) tick();
        check("t6_wberr_hold", {31'd0, wbError}, 32'd1);

        // Stall counter saturation
        issue(1, 0, 0, 0, 0, 1, 9); tick();
        issue(1, 9, 0, 1, 0, 0, 0);
        repeat (65540) tick();
        check("sat_stall", {16'd0, stallCount}, 32'h0000_FFFF);
        check("sat_wberr", {31'd0, wbError}, 32'd1);

        reset = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        check("rst2_stall", {16'd0, stallCount}, 32'd0);
        check("rst2_wberr", {31'd0, wbError}, 32'd0);

        // Randomized traffic; decode holds a stalled instruction stable
        m_accepted = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!issueValid || m_accepted) begin
                issue(($urandom_range(0, 9) < 7), pick_reg(), pick_reg(),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), pick_reg());
            end
            wbValid = 1'b0;
            if ($urandom_range(0, 99) < 40) begin
                logic [4:0] q[$];
                for (int i = 0; i < 32; i++) if (m_pend[i]) q.push_back(5'(i));
                if (q.size() > 0) begin
                    wbValid    = 1'b1;
                    wbRegister = q[$urandom_range(0, q.size() - 1)];
                end
            end else if ($urandom_range(0, 99) < 2) begin
                wbValid    = 1'b1;
                wbRegister = pick_reg();
            end
            flush = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
